// File: rtl/pzqhb_pkg.sv
// rtl/pzqhb_pkg.sv - shared types and constants for the pzqhb byte link
package pzqhb_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, HOLD} rx_state_t;

  typedef enum logic [1:0] {ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TMO} rx_err_t;

  localparam byte_t SOF_DEFAULT = 8'hA5;

  // A LEN byte is usable when it names between 1 and max_len payload bytes.
  function automatic logic len_ok(input byte_t b, input int unsigned max_len);
    return (b != 8'd0) && (32'(b) <= max_len);
  endfunction

endpackage

// File: rtl/pzqhb_rx_wdog.sv
// rtl/pzqhb_rx_wdog.sv - idle-cycle watchdog for the pzqhb receiver
module pzqhb_rx_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  // Expiry is seen in the same cycle the count would reach TIMEOUT; a clear in that cycle suppresses it.
  assign expire = enable & ~clear & (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || !enable || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pzqhb_rx.sv
// rtl/pzqhb_rx.sv - pzqhb frame receiver: SOF | LEN | payload | XOR checksum
module pzqhb_rx
  import pzqhb_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter byte_t       SOF_BYTE = SOF_DEFAULT,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:1][2:3][4:4][1:4]    rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic [MAX_LEN-1:0][7:0]      frame_data,
  output logic [7:0]                   frame_len,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [15:0]                  frame_cnt
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  rx_state_t     state;
  byte_t         rx_byte;
  byte_t         len_q;
  byte_t         xacc;
  logic [IW-1:0] idx;
  logic          beat;
  logic          tmo_en;
  logic          expire;
  logic          last_byte;

  assign rx_byte   = rx_data;
  assign rx_ready  = (state != HOLD);
  assign beat      = rx_valid & rx_ready;
  assign tmo_en    = (state == LEN) || (state == DATA) || (state == CHK);
  assign last_byte = (8'(idx) == (len_q - 8'd1));

  pzqhb_rx_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (beat),
    .enable (tmo_en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      xacc        <= '0;
      idx         <= '0;
      frame_data  <= '0;
      frame_len   <= '0;
      frame_valid <= 1'b0;
      err_valid   <= 1'b0;
      err_code    <= ERR_NONE;
      frame_cnt   <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (beat && (rx_byte == SOF_BYTE)) begin
            state <= LEN;
          end
        end

        LEN: begin
          if (beat) begin
            if (len_ok(rx_byte, MAX_LEN)) begin
              len_q      <= rx_byte;
              xacc       <= '0;
              idx        <= '0;
              frame_data <= '0;
              state      <= DATA;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_LEN;
              state     <= IDLE;
            end
          end else if (expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= IDLE;
          end
        end

        // SOF_BYTE arriving here is ordinary payload; there is no resync mid-frame.
        DATA: begin
          if (beat) begin
            frame_data[idx] <= rx_byte;
            xacc            <= xacc ^ rx_byte;
            idx             <= idx + IW'(1);
            if (last_byte) begin
              state <= CHK;
            end
          end else if (expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= IDLE;
          end
        end

        CHK: begin
          if (beat) begin
            if (rx_byte == xacc) begin
              frame_len   <= len_q;
              frame_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              err_valid <= 1'b1;
              err_code  <= ERR_CSUM;
              state     <= IDLE;
            end
          end else if (expire) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TMO;
            state     <= IDLE;
          end
        end

        HOLD: begin
          if (frame_ready) begin
            frame_valid <= 1'b0;
            frame_cnt   <= frame_cnt + 16'd1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pzqhb_rx.sv
// tb/tb_pzqhb_rx.sv - scoreboard bench for pzqhb_rx with directed frames
module tb_pzqhb_rx;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [1:1][2:3][4:4][1:4] rx_data;
  logic                      rx_valid = 1'b0;
  logic                      rx_ready;
  logic [15:0][7:0]          frame_data;
  logic [7:0]                frame_len;
  logic                      frame_valid;
  logic                      frame_ready = 1'b1;
  logic                      err_valid;
  logic [1:0]                err_code;
  logic [15:0]               frame_cnt;

  always #5 clk = ~clk;

  pzqhb_rx #(
    .MAX_LEN  (16),
    .SOF_BYTE (8'hA5),
    .TIMEOUT  (255)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_data  (frame_data),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .err_valid   (err_valid),
    .err_code    (err_code),
    .frame_cnt   (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit               is_err;
    logic [1:0]       code;
    logic [7:0]       len;
    logic [15:0][7:0] data;
    logic [15:0]      cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt = 16'd0;

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1;
    e.code   = c;
    e.len    = 8'd0;
    e.data   = '0;
    e.cnt    = 16'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] l, input logic [15:0][7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = 2'd0;
    e.len    = l;
    e.data   = d;
    e.cnt    = exp_cnt;
    exp_cnt  = exp_cnt + 16'd1;
    exp_q.push_back(e);
  endtask

  // Offer one byte and wait (bounded) until it is accepted on a rising edge.
  task automatic send(input logic [7:0] b);
    bit r;
    int n;
    r        = 1'b0;
    n        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!r && n < 100) begin
      @(negedge clk);
      r = rx_ready;
      @(posedge clk);
      n++;
    end
    #1 rx_valid = 1'b0;
    chk("send_accept", 128'(r), 128'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (err_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_err_valid", 128'(err_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("event_is_err", 128'(e.is_err), 128'(1));
          chk("err_code", 128'(err_code), 128'(e.code));
        end
      end
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_valid", 128'(frame_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("event_is_frame", 128'(e.is_err), 128'(0));
          chk("frame_len", 128'(frame_len), 128'(e.len));
          chk("frame_data", 128'(frame_data), 128'(e.data));
          chk("frame_cnt_before", 128'(frame_cnt), 128'(e.cnt));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0][7:0] d;
    rx_data = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 128'(rx_ready), 128'(1));
    chk("rst_frame_valid", 128'(frame_valid), 128'(0));
    chk("rst_frame_data", 128'(frame_data), 128'(0));
    chk("rst_frame_len", 128'(frame_len), 128'(0));
    chk("rst_err_valid", 128'(err_valid), 128'(0));
    chk("rst_err_code", 128'(err_code), 128'(0));
    chk("rst_frame_cnt", 128'(frame_cnt), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Good frame, checksum 11^22^33 = 00.
    d = '0; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    push_frame(8'd3, d);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    idle(1);
    @(negedge clk);
    chk("good_cnt", 128'(frame_cnt), 128'(1));
    chk("good_rx_ready", 128'(rx_ready), 128'(1));
    chk("good_frame_valid_low", 128'(frame_valid), 128'(0));
    idle(1);

    // Bad checksum: 0F^F0 = FF, sent 00.
    push_err(2'b10);
    send(8'hA5); send(8'h02); send(8'h0F); send(8'hF0); send(8'h00);
    idle(1);
    @(negedge clk);
    chk("csum_pulse_one_cycle", 128'(err_valid), 128'(0));
    chk("csum_code_held", 128'(err_code), 128'(2'b10));
    chk("csum_no_frame", 128'(frame_valid), 128'(0));
    chk("csum_rx_ready", 128'(rx_ready), 128'(1));
    idle(1);

    // Garbage before SOF, then LEN 0 and LEN 17.
    push_err(2'b01);
    send(8'h3C); send(8'h7E); send(8'hA5); send(8'h00);
    push_err(2'b01);
    send(8'hA5); send(8'h11);
    idle(2);
    chk("len_code_held", 128'(err_code), 128'(2'b01));
    chk("len_no_frame", 128'(frame_valid), 128'(0));

    // Backpressure with SOF value inside the payload: A5^5A = FF.
    frame_ready = 1'b0;
    d = '0; d[0] = 8'hA5; d[1] = 8'h5A;
    push_frame(8'd2, d);
    send(8'hA5); send(8'h02); send(8'hA5); send(8'h5A); send(8'hFF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_rx_ready", 128'(rx_ready), 128'(0));
      chk("bp_frame_valid", 128'(frame_valid), 128'(1));
      chk("bp_frame_data", 128'(frame_data), 128'(d));
      chk("bp_frame_len", 128'(frame_len), 128'(2));
      @(posedge clk);
      #1;
    end
    frame_ready = 1'b1;
    idle(1);
    @(negedge clk);
    chk("bp_cnt", 128'(frame_cnt), 128'(2));
    chk("bp_rx_ready_after", 128'(rx_ready), 128'(1));
    chk("bp_frame_valid_after", 128'(frame_valid), 128'(0));
    idle(1);

    // Timeout: 255 idle cycles inside DATA.
    push_err(2'b11);
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (254) @(posedge clk);
    @(negedge clk);
    chk("tmo_not_early", 128'(err_valid), 128'(0));
    @(posedge clk);
    @(negedge clk);
    chk("tmo_pulse", 128'(err_valid), 128'(1));
    chk("tmo_code", 128'(err_code), 128'(2'b11));
    idle(1);

    // Beat lands on the would-be expiry cycle: frame 01,02,03,04 checksum 04.
    d = '0; d[0] = 8'h01; d[1] = 8'h02; d[2] = 8'h03; d[3] = 8'h04;
    push_frame(8'd4, d);
    send(8'hA5); send(8'h04); send(8'h01);
    repeat (254) @(posedge clk);
    #1;
    send(8'h02); send(8'h03); send(8'h04); send(8'h04);
    idle(1);
    @(negedge clk);
    chk("tmo_race_cnt", 128'(frame_cnt), 128'(3));
    chk("tmo_race_code_held", 128'(err_code), 128'(2'b11));
    idle(1);

    // Reset in the middle of DATA.
    send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rx_ready", 128'(rx_ready), 128'(1));
    chk("mid_rst_frame_valid", 128'(frame_valid), 128'(0));
    chk("mid_rst_frame_data", 128'(frame_data), 128'(0));
    chk("mid_rst_frame_len", 128'(frame_len), 128'(0));
    chk("mid_rst_err_valid", 128'(err_valid), 128'(0));
    chk("mid_rst_err_code", 128'(err_code), 128'(0));
    chk("mid_rst_frame_cnt", 128'(frame_cnt), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 16'd0;
    @(negedge clk);
    chk("post_rst_no_err", 128'(err_valid), 128'(0));
    idle(1);

    d = '0; d[0] = 8'h7E;
    push_frame(8'd1, d);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7E);
    idle(1);
    @(negedge clk);
    chk("post_rst_cnt", 128'(frame_cnt), 128'(1));
    chk("post_rst_frame_data", 128'(frame_data), 128'(d));
    chk("post_rst_frame_len", 128'(frame_len), 128'(1));

    idle(5);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
